// File: rtl/g15_pkg.sv
// ---------------------------------------------------------------------------
// g15_pkg
// Shared definitions for the late-bus recomplementer (recomp_gate_lb).
//   WORD_BITS   : bits per serial word (sign at TS + 28 magnitude bits)
//   PAIR_WORDS  : depth of the delay line in words
//   DP_BITS     : magnitude width of a double-precision pair
//   rc_state_t  : magnitude-path FSM states
//   rc_meta_t   : per-group metadata carried from input side to output side
// ---------------------------------------------------------------------------
package g15_pkg;

    localparam int WORD_BITS  = 29;
    localparam int PAIR_WORDS = 2;
    localparam int DP_BITS    = 2 * WORD_BITS - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS   = 2'd1,
        COPY   = 2'd2,
        INVERT = 2'd3
    } rc_state_t;

    typedef struct packed {
        logic valid;     // group started with WV=1 at a TS
        logic sign;      // complement-form sign captured at TS
        logic dp;        // group is a double-precision pair
        logic mag_zero;  // whole magnitude of the group was zero
    } rc_meta_t;

    // Sign actually emitted: a negative zero is reported as +0.
    function automatic logic meta_out_sign(input rc_meta_t m);
        return m.sign & ~m.mag_zero;
    endfunction

    // Group whose magnitude ends at the TE of the word that opened it.
    function automatic logic meta_is_single(input rc_meta_t m);
        return m.valid & ~m.dp;
    endfunction

endpackage

// File: rtl/serial_recomp.sv
// ---------------------------------------------------------------------------
// serial_recomp
// Bit-serial magnitude recomplementer and output mux. Converts an LSB-first
// two's-complement magnitude back to true magnitude when the group is
// negative: bits are copied up to and including the first 1, every later bit
// is inverted.
//   clk     in   bit clock
//   rst     in   asynchronous active-high reset
//   start   in   output TS of a valid group (sign slot)
//   last    in   final bit time of the group (TE of single / DP second word)
//   neg     in   group sign from metadata
//   zero    in   group magnitude was all zero
//   d_in    in   delayed serial data (complement form)
//   d_out   out  serial sign-magnitude data
//   active  out  an output group is in progress this cycle
// ---------------------------------------------------------------------------
module serial_recomp
    import g15_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic last,
    input  logic neg,
    input  logic zero,
    input  logic d_in,
    output logic d_out,
    output logic active
);

    rc_state_t state_q;
    rc_state_t state_d;
    logic      neg_eff;

    // A negative zero is treated as positive: its magnitude is copied as is.
    assign neg_eff = neg & ~zero;

    always_comb begin
        state_d = state_q;
        d_out   = 1'b0;
        if (start) begin
            // Sign slot: emit the corrected sign, choose the magnitude path.
            d_out   = neg_eff;
            state_d = neg_eff ? COPY : PASS;
        end else begin
            case (state_q)
                IDLE: begin
                    d_out = 1'b0;
                end
                PASS: begin
                    d_out = d_in;
                end
                COPY: begin
                    d_out = d_in;
                    if (d_in) begin
                        state_d = INVERT;
                    end
                end
                INVERT: begin
                    d_out = ~d_in;
                end
                default: begin
                    d_out   = 1'b0;
                    state_d = IDLE;
                end
            endcase
            // The DP word boundary is not a group end; only the true last
            // bit returns the FSM to IDLE.
            if (last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign active = start | (state_q != IDLE);

endmodule

// File: rtl/sr_ff.sv
// ---------------------------------------------------------------------------
// sr_ff
// Single-bit set/clear flag register, set has priority over clear.
//   clk  in  clock
//   rst  in  asynchronous active-high reset, clears the flag
//   set  in  force flag to 1 at the next edge
//   clr  in  force flag to 0 at the next edge (when set is low)
//   q    out registered flag
// ---------------------------------------------------------------------------
module sr_ff (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);

    logic flag_q;
    logic flag_d;

    always_comb begin
        flag_d = flag_q;
        if (set) begin
            flag_d = 1'b1;
        end else if (clr) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign q = flag_q;

endmodule

// File: rtl/recomp_gate_lb.sv
// ---------------------------------------------------------------------------
// recomp_gate_lb
// Late-bus recomplementer. Serial complement-form words are delayed by a
// fixed two words so that the zero-ness of the whole magnitude is known
// before the sign bit is emitted; negative values are recomplemented to
// sign-magnitude and -0 is forced to +0.
//   CLOCK   in   bit clock
//   rst     in   asynchronous active-high reset
//   TS      in   sign bit time (first cycle of every word)
//   TE      in   last bit time of every word
//   LB_IN   in   serial complement-form data, sign at TS then magnitude LSB first
//   WV      in   word valid, sampled at TS (ignored at a DP second word's TS)
//   DP      in   sampled with WV: word opens a double-precision pair
//   LB_OUT  out  serial sign-magnitude data, delayed PAIR_WORDS words
//   OV      out  high for every cycle of a valid output word
//   SGN     out  sign of the current output group, held TS..TE
//   MZ      out  one-cycle pulse at output TS when -0 was forced to +0
// ---------------------------------------------------------------------------
module recomp_gate_lb #(
    parameter int WORD_BITS  = 29,
    parameter int PAIR_WORDS = 2
) (
    input  logic CLOCK,
    input  logic rst,
    input  logic TS,
    input  logic TE,
    input  logic LB_IN,
    input  logic WV,
    input  logic DP,
    output logic LB_OUT,
    output logic OV,
    output logic SGN,
    output logic MZ
);

    import g15_pkg::rc_meta_t;
    import g15_pkg::meta_out_sign;
    import g15_pkg::meta_is_single;

    localparam int LINE_BITS = PAIR_WORDS * WORD_BITS;

    // ------------------------------------------------------------------
    // Input side state
    // ------------------------------------------------------------------
    logic [LINE_BITS-1:0] line_q;
    logic [LINE_BITS-1:0] line_d;
    logic                 acc_q;       // OR of magnitude bits seen so far
    logic                 acc_d;
    logic                 word_dp2_q;  // current input word is a DP second word
    logic                 word_dp2_d;
    logic                 pend_q;      // next input word is a DP second word

    // Two-entry metadata queue, one entry per word slot. meta0 belongs to
    // the word currently entering; meta1 to the word before it. At a TS
    // meta1 is exactly the group whose first output bit leaves this cycle.
    rc_meta_t meta0_q;
    rc_meta_t meta0_d;
    rc_meta_t meta1_q;
    rc_meta_t meta1_d;

    logic accept;
    logic zero_now;

    // ------------------------------------------------------------------
    // Output side state
    // ------------------------------------------------------------------
    logic out_start;
    logic out_last;
    logic out_sign;
    logic out_pair_q;  // output is in the first word of a DP pair
    logic sgn_q;
    logic rc_bit;
    logic rc_active;

    assign accept   = TS & WV & ~pend_q;
    // Includes the bit on the wire now so the TE bit counts.
    assign zero_now = ~(acc_q | LB_IN);

    always_comb begin
        line_d     = {line_q[LINE_BITS-2:0], LB_IN};

        // TS slot is the sign for a group start (excluded from the magnitude)
        // but magnitude bit 29 for a DP second word (accumulated).
        if (TS) begin
            acc_d = pend_q & (acc_q | LB_IN);
        end else begin
            acc_d = acc_q | LB_IN;
        end

        word_dp2_d = TS ? pend_q : word_dp2_q;

        meta0_d = meta0_q;
        meta1_d = meta1_q;
        if (TS) begin
            meta1_d = meta0_q;
            meta0_d = '0;
            if (accept) begin
                meta0_d.valid    = 1'b1;
                meta0_d.sign     = LB_IN;
                meta0_d.dp       = DP;
                meta0_d.mag_zero = 1'b0;
            end
        end else if (TE) begin
            // A DP pair's entry has already moved to meta1 by its second TE.
            if (word_dp2_q) begin
                meta1_d.mag_zero = zero_now;
            end else if (meta_is_single(meta0_q)) begin
                meta0_d.mag_zero = zero_now;
            end
        end
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            line_q     <= '0;
            acc_q      <= 1'b0;
            word_dp2_q <= 1'b0;
            meta0_q    <= '0;
            meta1_q    <= '0;
        end else begin
            line_q     <= line_d;
            acc_q      <= acc_d;
            word_dp2_q <= word_dp2_d;
            meta0_q    <= meta0_d;
            meta1_q    <= meta1_d;
        end
    end

    sr_ff u_pend (
        .clk (CLOCK),
        .rst (rst),
        .set (accept & DP),
        .clr (TS & pend_q),
        .q   (pend_q)
    );

    // ------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------
    assign out_start = TS & meta1_q.valid;
    assign out_sign  = meta_out_sign(meta1_q);
    // TE of a DP pair's first word is not the end of the group.
    assign out_last  = TE & ~out_pair_q;

    sr_ff u_pair (
        .clk (CLOCK),
        .rst (rst),
        .set (out_start & meta1_q.dp),
        .clr (TS & ~out_start),
        .q   (out_pair_q)
    );

    sr_ff u_sgn (
        .clk (CLOCK),
        .rst (rst),
        .set (out_start & out_sign),
        .clr ((out_start & ~out_sign) | out_last),
        .q   (sgn_q)
    );

    serial_recomp u_recomp (
        .clk    (CLOCK),
        .rst    (rst),
        .start  (out_start),
        .last   (out_last),
        .neg    (meta1_q.sign),
        .zero   (meta1_q.mag_zero),
        .d_in   (line_q[LINE_BITS-1]),
        .d_out  (rc_bit),
        .active (rc_active)
    );

    assign LB_OUT = rc_bit;
    assign OV     = rc_active;
    // The popped entry is only visible in the TS cycle; sgn_q holds it after.
    assign SGN    = out_start ? out_sign : sgn_q;
    assign MZ     = out_start & meta1_q.sign & meta1_q.mag_zero;

endmodule
